// File: rtl/bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial
//
// Serial binary-to-BCD converter (shift-and-add-3 / double-dabble), one input
// bit per clock. Produces a packed DIGITS-digit BCD word for a 7-segment
// decoder, plus an overflow flag when the value needs more than DIGITS digits.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   bin_in is valid this cycle
//   in_ready   out  converter idle, accepts bin_in
//   bin_in     in   BIN_W-bit unsigned binary value
//   out_valid  out  one-cycle pulse: bcd_out / ovf were just updated
//   bcd_out    out  packed BCD, most significant digit in the top nibble
//   ovf        out  last conversion did not fit in DIGITS digits
//
// Handshake: a value is accepted on any rising edge where in_valid and
// in_ready are both high. in_valid seen while in_ready is low is dropped
// (no queuing); the source holds in_valid until it observes in_ready.
//
// Build option: define BIN2BCD_SAT_EN to saturate bcd_out to all nines on
// overflow; otherwise bcd_out is driven to all ones (blanking code).
// -----------------------------------------------------------------------------
module bin_to_bcd_serial #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    // DIGITS+1 nibbles sit above the binary field; the extra top nibble
    // catches values that need one more decimal digit.
    localparam int SR_W  = 4 * (DIGITS + 1) + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

`ifdef BIN2BCD_SAT_EN
    localparam logic [BCD_W-1:0] OVF_CODE = {DIGITS{4'h9}};
`else
    localparam logic [BCD_W-1:0] OVF_CODE = {BCD_W{1'b1}};
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [SR_W-1:0]  sr_adj;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       top_nib;

    // Add-3 correction on every BCD nibble that is 5 or more, taken from the
    // current register; the shift happens on the same edge.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i <= DIGITS; i++) begin
            if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    assign top_nib = sr_q[BIN_W + BCD_W +: 4];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d    = {{(4*(DIGITS+1)){1'b0}}, bin_in};
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_d = 1'b1;
                ovf_d       = (top_nib != 4'd0);
                bcd_d       = (top_nib != 4'd0) ? OVF_CODE : sr_q[BIN_W +: BCD_W];
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// Testbench for bin_to_bcd_serial: default instance (BIN_W=7, DIGITS=2) and a
// wide instance (BIN_W=10, DIGITS=3), checked against a decimal reference
// model built from integer division/modulo.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_serial;

    logic clk = 1'b0;
    logic rst_n;

    logic        in_valid0;
    logic        in_ready0;
    logic [6:0]  bin_in0;
    logic        out_valid0;
    logic [7:0]  bcd0;
    logic        ovf0;

    logic        in_valid1;
    logic        in_ready1;
    logic [9:0]  bin_in1;
    logic        out_valid1;
    logic [11:0] bcd1;
    logic        ovf1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_serial #(.BIN_W(7), .DIGITS(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .bin_in(bin_in0), .out_valid(out_valid0), .bcd_out(bcd0), .ovf(ovf0)
    );

    bin_to_bcd_serial #(.BIN_W(10), .DIGITS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .bin_in(bin_in1), .out_valid(out_valid1), .bcd_out(bcd1), .ovf(ovf1)
    );

    // Reference: decimal digits by division, or the overflow code.
    function automatic logic [31:0] ref_bcd(input int v, input int digits);
        int lim;
        int t;
        logic [31:0] r;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        r = '0;
        if (v >= lim) begin
`ifdef BIN2BCD_SAT_EN
            for (int i = 0; i < digits; i++) r = (r << 4) | 32'd9;
`else
            r = (32'd1 << (4 * digits)) - 32'd1;
`endif
        end else begin
            t = v;
            for (int i = 0; i < digits; i++) begin
                r = r | (32'(t % 10) << (4 * i));
                t = t / 10;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Convert one value on dut0. hold: keep in_valid high (back-to-back).
    // glitch: three cycles after accept, switch bin_in to 80 and pulse in_valid.
    task automatic conv0(input int v, input bit hold, input bit glitch);
        int n;
        int lat;
        bit busy_ok;
        logic [31:0] exp;
        n = 0;
        while (in_ready0 !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_accept", 32'(in_ready0), 32'd1);
        bin_in0   = 7'(v);
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        if (!hold) in_valid0 = 1'b0;
        bin_in0 = 7'($urandom_range(0, 127));
        lat     = 0;
        busy_ok = 1'b1;
        while (out_valid0 !== 1'b1 && lat < 40) begin
            if (in_ready0 !== 1'b0) busy_ok = 1'b0;
            if (glitch && lat == 3) begin
                bin_in0   = 7'd80;
                in_valid0 = 1'b1;
            end
            if (glitch && lat == 4) in_valid0 = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        exp = ref_bcd(v, 2);
        check("latency0", 32'(lat), 32'd8);
        check("in_ready_busy0", 32'(busy_ok), 32'd1);
        check("in_ready_at_done0", 32'(in_ready0), 32'd1);
        check("bcd0", 32'(bcd0), exp);
        check("ovf0", 32'(ovf0), 32'(v >= 100));
        if (!hold) begin
            @(posedge clk); #1;
            check("out_valid_pulse0", 32'(out_valid0), 32'd0);
            check("bcd_held0", 32'(bcd0), exp);
        end
    endtask

    task automatic conv1(input int v);
        int n;
        int lat;
        n = 0;
        while (in_ready1 !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        bin_in1   = 10'(v);
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        bin_in1   = 10'($urandom_range(0, 1023));
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency1", 32'(lat), 32'd11);
        check("bcd1", 32'(bcd1), ref_bcd(v, 3));
        check("ovf1", 32'(ovf1), 32'(v >= 1000));
    endtask

    initial begin : main
        bit quiet;
        // Clock/reset
        rst_n     = 1'b0;
        in_valid0 = 1'b0;
        bin_in0   = '0;
        in_valid1 = 1'b0;
        bin_in1   = '0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_bcd", 32'(bcd0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_in_ready1", 32'(in_ready1), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero, single pulse
        conv0(0, 1'b0, 1'b0);

        // Back-to-back sweep 0..99 with in_valid held
        for (int v = 0; v < 100; v++) conv0(v, 1'b1, 1'b0);
        in_valid0 = 1'b0;
        @(posedge clk); #1;

        // Overflow boundaries
        conv0(100, 1'b0, 1'b0);
        conv0(127, 1'b0, 1'b0);
        conv0(99, 1'b0, 1'b0);

        // Random values with random idle gaps
        repeat (20) begin
            conv0(int'($urandom_range(0, 127)), 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        // bin_in change and in_valid pulse while busy are ignored
        conv0(35, 1'b0, 1'b1);
        quiet = 1'b1;
        repeat (12) begin
            if (out_valid0 !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        check("no_extra_out_valid", 32'(quiet), 32'd1);

        // Leave ovf/bcd nonzero, then reset mid-conversion of 63
        conv0(127, 1'b0, 1'b0);
        bin_in0   = 7'd63;
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready0), 32'd1);
        check("midrst_out_valid", 32'(out_valid0), 32'd0);
        check("midrst_bcd", 32'(bcd0), 32'd0);
        check("midrst_ovf", 32'(ovf0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            if (out_valid0 !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        check("midrst_no_out_valid", 32'(quiet), 32'd1);
        conv0(12, 1'b0, 1'b0);

        // Wide instance
        conv1(999);
        conv1(1000);
        conv1(1023);
        conv1(0);
        repeat (8) conv1(int'($urandom_range(0, 1023)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
